// File: rtl/systolic_feeder_pkg.sv
// ---------------------------------------------------------------------------
// systolic_feeder_pkg : shared types and constants for the systolic feeder
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package systolic_feeder_pkg;

  localparam int PE_DATA_W = 8;
  localparam int ARR_DIM   = 4;

  localparam int FEED_LEN  = 2 * ARR_DIM - 1;
  localparam int FLUSH_LEN = ARR_DIM - 1;
  localparam int DRAIN_LEN = ARR_DIM;

  // Wide enough for the longest phase (FEED).
  localparam int CNT_W = $clog2(FEED_LEN);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FEED  = 3'd1,
    S_FLUSH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

endpackage

`default_nettype wire

// File: rtl/systolic_feeder_skew_lane.sv
// ---------------------------------------------------------------------------
// systolic_feeder_skew_lane : registered per-lane skew selector (skew_lane)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_feeder_skew_lane
  import systolic_feeder_pkg::*;
#(
  parameter int N    = PE_DATA_W,
  parameter int DIM  = ARR_DIM,
  parameter int LANE = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  logic [CNT_W-1:0]       t_i,
  input  logic [DIM-1:0][N-1:0]  elems_i,
  output logic [N-1:0]           data_o
);

  localparam int IW = $clog2(DIM);

  logic [CNT_W-1:0] rel;
  logic             hit;
  logic [N-1:0]     data_d;
  logic [N-1:0]     data_q;

  // Lane LANE is delayed by LANE cycles; element index is t - LANE.
  assign rel = t_i - CNT_W'(LANE);
  assign hit = en_i && (t_i >= CNT_W'(LANE)) && (rel < CNT_W'(DIM));

  always_comb begin
    data_d = '0;
    if (hit) begin
      data_d = elems_i[rel[IW-1:0]];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

`default_nettype wire

// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder : stores A/B and streams them skewed into a 4x4 PE array
// Optional macro: FEEDER_DOUBLE_BUF_EN (shadow + active store banks). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_feeder
  import systolic_feeder_pkg::*;
#(
  parameter int N   = PE_DATA_W,
  parameter int DIM = ARR_DIM
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         wr_sel,
  input  logic [3:0]   wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] row_0,
  output logic [N-1:0] row_1,
  output logic [N-1:0] row_2,
  output logic [N-1:0] row_3,
  output logic [N-1:0] col_0,
  output logic [N-1:0] col_1,
  output logic [N-1:0] col_2,
  output logic [N-1:0] col_3,
  output logic         output_sign
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_acc;
  logic             feed_d;

  logic [DIM*DIM-1:0][N-1:0] a_q, a_d;
  logic [DIM*DIM-1:0][N-1:0] b_q, b_d;
`ifdef FEEDER_DOUBLE_BUF_EN
  logic [DIM*DIM-1:0][N-1:0] sa_q, sa_d;
  logic [DIM*DIM-1:0][N-1:0] sb_q, sb_d;
`endif

  logic [DIM-1:0][N-1:0] row_w;
  logic [DIM-1:0][N-1:0] col_w;

  assign start_acc = start && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FEED;
          cnt_d   = '0;
        end
      end
      S_FEED: begin
        if (cnt_q == CNT_W'(FEED_LEN - 1)) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_FLUSH: begin
        if (cnt_q == CNT_W'(FLUSH_LEN - 1)) begin
          state_d = S_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (cnt_q == CNT_W'(DRAIN_LEN - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Lanes read the next-state store so a same-edge write is visible at t=0.
  always_comb begin
    a_d = a_q;
    b_d = b_q;
`ifdef FEEDER_DOUBLE_BUF_EN
    sa_d = sa_q;
    sb_d = sb_q;
    if (wr_en) begin
      if (wr_sel) begin
        sb_d[wr_addr] = wr_data;
      end else begin
        sa_d[wr_addr] = wr_data;
      end
    end
    if (start_acc) begin
      a_d = sa_d;
      b_d = sb_d;
    end
`else
    if (wr_en && (state_q == S_IDLE)) begin
      if (wr_sel) begin
        b_d[wr_addr] = wr_data;
      end else begin
        a_d[wr_addr] = wr_data;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
`ifdef FEEDER_DOUBLE_BUF_EN
      sa_q    <= '0;
      sb_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
`ifdef FEEDER_DOUBLE_BUF_EN
      sa_q    <= sa_d;
      sb_q    <= sb_d;
`endif
    end
  end

  assign feed_d = (state_d == S_FEED);

  for (genvar i = 0; i < DIM; i++) begin : g_lane
    logic [DIM-1:0][N-1:0] row_elems;
    logic [DIM-1:0][N-1:0] col_elems;

    for (genvar k = 0; k < DIM; k++) begin : g_elem
      assign row_elems[k] = a_d[i*DIM + k];
      assign col_elems[k] = b_d[k*DIM + i];
    end

    systolic_feeder_skew_lane #(
      .N    (N),
      .DIM  (DIM),
      .LANE (i)
    ) u_row (
      .clk     (clk),
      .rst     (rst),
      .en_i    (feed_d),
      .t_i     (cnt_d),
      .elems_i (row_elems),
      .data_o  (row_w[i])
    );

    systolic_feeder_skew_lane #(
      .N    (N),
      .DIM  (DIM),
      .LANE (i)
    ) u_col (
      .clk     (clk),
      .rst     (rst),
      .en_i    (feed_d),
      .t_i     (cnt_d),
      .elems_i (col_elems),
      .data_o  (col_w[i])
    );
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign output_sign = (state_q == S_DRAIN);

  assign row_0 = row_w[0];
  assign row_1 = row_w[1];
  assign row_2 = row_w[2];
  assign row_3 = row_w[3];
  assign col_0 = col_w[0];
  assign col_1 = col_w[1];
  assign col_2 = col_w[2];
  assign col_3 = col_w[3];

endmodule

`default_nettype wire

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder : scoreboard bench for systolic_feeder (DIM=4, N=8)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_systolic_feeder;

  typedef struct packed {
    logic            busy;
    logic            done;
    logic            os;
    logic [3:0][7:0] rows;
    logic [3:0][7:0] cols;
  } obs_t;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic       wr_sel;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] row_0, row_1, row_2, row_3;
  logic [7:0] col_0, col_1, col_2, col_3;
  logic       output_sign;

  int total;
  int bad;

  logic [7:0] ma [16];
  logic [7:0] mb [16];
`ifdef FEEDER_DOUBLE_BUF_EN
  logic [7:0] sa [16];
  logic [7:0] sb [16];
`endif

  obs_t exp_q[$];

  systolic_feeder #(.N(8), .DIM(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .row_0       (row_0),
    .row_1       (row_1),
    .row_2       (row_2),
    .row_3       (row_3),
    .col_0       (col_0),
    .col_1       (col_1),
    .col_2       (col_2),
    .col_3       (col_3),
    .output_sign (output_sign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  function automatic obs_t cur_obs();
    obs_t o;
    o.busy    = busy;
    o.done    = done;
    o.os      = output_sign;
    o.rows[0] = row_0;
    o.rows[1] = row_1;
    o.rows[2] = row_2;
    o.rows[3] = row_3;
    o.cols[0] = col_0;
    o.cols[1] = col_1;
    o.cols[2] = col_2;
    o.cols[3] = col_3;
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      ma[i] = 8'h00;
      mb[i] = 8'h00;
`ifdef FEEDER_DOUBLE_BUF_EN
      sa[i] = 8'h00;
      sb[i] = 8'h00;
`endif
    end
  endtask

  task automatic model_write(input logic sel, input int addr, input logic [7:0] data,
                             input logic in_run);
`ifdef FEEDER_DOUBLE_BUF_EN
    if (sel) sb[addr] = data;
    else     sa[addr] = data;
`else
    if (!in_run) begin
      if (sel) mb[addr] = data;
      else     ma[addr] = data;
    end
`endif
  endtask

  // Expected outputs for cycles 0..14 of a run plus the first idle cycle.
  task automatic push_run();
    obs_t e;
`ifdef FEEDER_DOUBLE_BUF_EN
    ma = sa;
    mb = sb;
`endif
    for (int c = 0; c < 16; c++) begin
      e      = '0;
      e.busy = (c <= 14);
      e.done = (c == 14);
      e.os   = (c >= 10) && (c <= 13);
      if (c < 7) begin
        for (int i = 0; i < 4; i++) begin
          if ((c - i >= 0) && (c - i < 4)) begin
            e.rows[i] = ma[i*4 + (c - i)];
            e.cols[i] = mb[(c - i)*4 + i];
          end
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic load(input int mode);
    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        wr_en   = 1'b1;
        wr_sel  = s[0];
        wr_addr = a[3:0];
        if (mode == 0) wr_data = (s == 0) ? ((a / 4 == a % 4) ? 8'd1 : 8'd0) : 8'(a + 1);
        else           wr_data = (s == 0) ? 8'd2 : 8'd3;
        model_write(s[0], a, wr_data, 1'b0);
        tick();
      end
    end
    wr_en = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    push_run();
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    obs_t got;
    @(negedge clk);
    got = cur_obs();
    total++;
    if (got !== obs_t'(0)) begin
      bad++;
      $display("FAIL reset got=%h want=%h", got, obs_t'(0));
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_identity();
    obs_t e, got;
    load(0);
    launch();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = cur_obs();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL identity c%0d got=%h want=%h", k, got, e);
      end
      tick();
    end
  endtask

  task automatic test_full_run();
    obs_t e, got;
    load(1);
    launch();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = cur_obs();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL full_run c%0d got=%h want=%h", k, got, e);
      end
      tick();
    end
  endtask

  task automatic test_restart_ignored();
    obs_t e, got;
    launch();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = cur_obs();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL restart c%0d got=%h want=%h", k, got, e);
      end
      tick();
      if (k == 4) start = 1'b1;
      if (k == 5) start = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    obs_t e, got;
    launch();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = cur_obs();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL back_to_back c%0d got=%h want=%h", k, got, e);
      end
      tick();
    end
  endtask

  task automatic test_write_busy();
    obs_t e, got;
    launch();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = cur_obs();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL write_busy c%0d got=%h want=%h", k, got, e);
      end
      tick();
      if (k == 4) begin
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = 4'd5;
        wr_data = 8'h55;
        model_write(1'b0, 5, 8'h55, 1'b1);
      end
      if (k == 5) wr_en = 1'b0;
    end
    launch();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = cur_obs();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL write_busy_next c%0d got=%h want=%h", k, got, e);
      end
      tick();
    end
  endtask

  task automatic test_write_with_start();
    obs_t e, got;
    wr_en   = 1'b1;
    wr_sel  = 1'b1;
    wr_addr = 4'd15;
    wr_data = 8'hFF;
    model_write(1'b1, 15, 8'hFF, 1'b0);
    start = 1'b1;
    push_run();
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = cur_obs();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL write_start c%0d got=%h want=%h", k, got, e);
      end
      tick();
    end
  endtask

  task automatic test_reset_midrun();
    obs_t e, got;
    launch();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      if (k >= 8) e = '0;
      got = cur_obs();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset_midrun c%0d got=%h want=%h", k, got, e);
      end
      tick();
      if (k == 7) begin
        rst = 1'b1;
        model_clear();
      end
      if (k == 8) rst = 1'b0;
    end
    launch();
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      e   = exp_q.pop_front();
      got = cur_obs();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset_rerun c%0d got=%h want=%h", k, got, e);
      end
      tick();
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    wr_en   = 1'b0;
    wr_sel  = 1'b0;
    wr_addr = 4'd0;
    wr_data = 8'd0;
    start   = 1'b0;
    model_clear();

    test_reset();
    test_identity();
    test_full_run();
    test_restart_ignored();
    test_back_to_back();
    test_write_busy();
    test_write_with_start();
    test_reset_midrun();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/systolic_feeder.md
# systolic_feeder

Source-side driver for the 4x4 output-stationary PE array. Stores one A matrix and one B matrix, then streams them into the array with diagonal skew: A rows enter from the left, B columns from the top. After the last MAC has settled it asserts the array's output-shift control for exactly DIM cycles so results drain out of the row outputs, and then reports completion.

## Interface
- N, default 8: element width; matches the array data width.
- DIM, default 4: array dimension; the block is verified at 4 only.
- clk  in  1  rising-edge clock
- rst  in  1  **reset is asynchronous and active-high**
- wr_en  in  1  write strobe for the matrix store
- wr_sel  in  1  0 = write A, 1 = write B
- wr_addr  in  4  element address, row*DIM+col
- wr_data  in  N  element value
- start  in  1  single-cycle request to run one multiply
- busy  out  1  high from the cycle after an accepted start through the DONE state
- done  out  1  one-cycle pulse at the end of a run
- row_0..row_3  out  N each  skewed A stream to array left edge
- col_0..col_3  out  N each  skewed B stream to array top edge
- output_sign  out  1  drain control to every PE

## Operation
- Store: two DIMxDIM arrays of N bits (A, B). A write with wr_en=1 lands on the next edge. Writes while busy=1 are dropped unless double buffering is enabled (see Configuration).
- FSM states: IDLE → FEED → FLUSH → DRAIN → DONE → IDLE.
  - IDLE: start=1 → FEED and local counter t=0. A start while not IDLE is ignored.
  - FEED: 2*DIM-1 cycles, t=0..6.
    - row_i = A[i][t-i] when 0≤t-i<DIM, else 0.
    - col_j = B[t-j][j] when 0≤t-j<DIM, else 0.
  - FLUSH: DIM-1 cycles. All streams are 0. This lets PE(3,3) absorb its last operand pair, which arrives at t = 3*DIM-3.
  - DRAIN: DIM cycles with output_sign=1 and streams 0.
  - DONE: one cycle with done=1, then IDLE.
- The run length from start acceptance to the done pulse is 2*DIM-1 + DIM-1 + DIM + 1 = 15 cycles at DIM=4.
- Each stream output is registered. Unused operand slots are always exactly 0, never stale data.

## Timing
- Reset values: busy=0, done=0, output_sign=0, all row/col outputs 0, FSM IDLE, t=0, store cleared to 0.
- Asserting rst mid-run aborts the run immediately: outputs return to their reset values, done is not pulsed, and stored data is cleared.
- start is sampled at edge E0. On that edge busy goes high, and row_0/col_0 present A[0][0]/B[0][0].
- output_sign is high on cycles 10..13 after start. done is high on cycle 14. busy falls together with done.
- A write and a start in the same IDLE cycle: the write commits and the run uses the new value.
- In the last DRAIN cycle the FSM moves to DONE. There is no extra shift cycle.

## Configuration
- FEEDER_DOUBLE_BUF_EN defined:
  - The store has two banks, active and shadow.
  - Writes always go to shadow, even while busy.
  - An accepted start first copies shadow into active on the same edge, then the run reads from active.
  - Back-to-back runs can therefore be loaded during drain.
- FEEDER_DOUBLE_BUF_EN undefined: a single bank; writes while busy are dropped.

## Structure
- Shared package holds:
  - The FSM state enum: S_IDLE, S_FEED, S_FLUSH, S_DRAIN, S_DONE.
  - FEED_LEN = 2*DIM-1, FLUSH_LEN = DIM-1, DRAIN_LEN = DIM.
  - The element-width constant shared with the PE array.
- One natural sub-module, skew_lane: a per-lane selector taking lane index, t, and the lane's DIM elements, and emitting the registered element or 0. It is instantiated 2*DIM times (rows and columns).

## Test plan
- A = identity, B[k][j] = 4k+j+1, start → row_0..3 show 1s on the diagonal at t=0,2,4,6. col_2 shows 3,7,11,15 at t=2..5. done on cycle 14.
- Full run with A = all 2, B = all 3 → output_sign high on exactly cycles 10–13. All streams 0 from cycle 7 onward. busy high on cycles 0–14.
- start pulsed again at t=5 of a run → ignored, with no change in timing. Second start in IDLE → identical 15-cycle run.
- Write A[1][1]=0x55 while busy (macro off) → dropped, so the next run still feeds the old value. With the macro on, the next run feeds 0x55.
- rst asserted at t=8 → all outputs 0 in the same cycle, no done pulse, store reads back 0 on the next run.
- Write wr_addr=15, wr_sel=1, value 0xFF together with start in IDLE → col_3 emits 0xFF at t=6.
